// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lets one requester at a time load a shared capture
// register. Bursts are capped at MAX_HOLD beats, then the grant rotates.
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [DATA_W-1:0]           q_o,
  output logic                        q_valid_o,
  output logic                        busy_o
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                           state, state_nxt;
  logic [IW-1:0]                    owner, owner_nxt, ptr, ptr_nxt, ptr_rel;
  logic [CW-1:0]                    cnt, cnt_nxt;
  logic [NUM_REQ-1:0]               gnt_nxt, masked;
  logic [NUM_REQ-1:0][DATA_W-1:0]   lane;
  logic                             beat, last;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = data_i[g*DATA_W +: DATA_W];
  end

  // First set bit of r, scanning upward from base and wrapping.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [IW-1:0] base);
    logic [IW-1:0] idx;
    logic          hit;
    rr_pick = base;
    hit     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IW'((int'(base) + i) % NUM_REQ);
      if (!hit && r[idx]) begin
        rr_pick = idx;
        hit     = 1'b1;
      end
    end
  endfunction

  assign beat    = (state == GRANT) && req_i[owner];
  assign last    = beat && (cnt == CW'(MAX_HOLD - 1));
  assign ptr_rel = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign masked  = req_i & ~(NUM_REQ'(1) << owner);
  assign busy_o  = |gnt_o;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (|req_i) begin
          state_nxt = GRANT;
          owner_nxt = rr_pick(req_i, ptr);
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (beat) cnt_nxt = cnt + 1'b1;
        if (!beat || last) begin
          ptr_nxt = ptr_rel;
          cnt_nxt = '0;
          // Others get first shot; the old owner only keeps it when alone.
          if (|masked)   owner_nxt = rr_pick(masked, ptr_rel);
          else if (beat) owner_nxt = owner;
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GRANT) gnt_nxt[owner_nxt] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      gnt_o     <= '0;
      q_o       <= '0;
      q_valid_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      gnt_o     <= gnt_nxt;
      q_valid_o <= beat;
      if (beat) q_o <= lane[owner];
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed plus randomized bench for shared_reg_arbiter against a cycle-level
// behavioural model of the round-robin capture rules.
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int H = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   data = '0;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             qv, busy;

  shared_reg_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_HOLD(H)) dut (
    .clk(clk), .reset(reset), .req_i(req), .data_i(data),
    .gnt_o(gnt), .q_o(q), .q_valid_o(qv), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: owner -1 means idle.
  int          m_owner = -1;
  int          m_ptr   = 0;
  int          m_cnt   = 0;
  logic [W-1:0] m_q    = '0;
  logic        m_qv    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int base);
    for (int i = 0; i < N; i++) begin
      if (r[(base + i) % N]) return (base + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int k;
    logic [N-1:0] m;
    logic b;
    if (!reset) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_q = '0; m_qv = 1'b0;
    end else if (m_owner < 0) begin
      m_qv = 1'b0;
      if (req != 0) m_owner = pick(req, m_ptr);
    end else begin
      k = m_owner;
      b = req[k];
      m_qv = b;
      if (b) begin
        m_q = data[k*W +: W];
        m_cnt++;
      end
      if (!b || m_cnt == H) begin
        m_ptr = (k + 1) % N;
        m_cnt = 0;
        m = req;
        m[k] = 1'b0;
        if (m != 0) m_owner = pick(m, m_ptr);
        else if (b) m_owner = k;
        else m_owner = -1;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = '0;
    if (m_owner >= 0) e[m_owner] = 1'b1;
    chk("gnt", gnt, e);
    chk("q", q, m_q);
    chk("q_valid", qv, m_qv);
    chk("busy", busy, m_owner >= 0);
  endtask

  initial begin
    int bc;
    logic [N-1:0] e;

    // Reset with all requests up.
    reset = 1'b0; req = 4'b1111;
    step(); step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_q", q, 8'h00);
    chk("rst_qv", qv, 1'b0);
    reset = 1'b1;
    step();
    chk("first_gnt", gnt, 4'b0001);

    // Full rotation with every requester asking.
    for (int s = 2; s <= 17; s++) begin
      for (int k = 0; k < N; k++) data[k*W +: W] = 8'(k * 16 + m_cnt);
      step();
      e = '0;
      e[((s - 1) / 4) % 4] = 1'b1;
      chk("rot_gnt", gnt, e);
      chk("rot_q", q, 8'(((s - 2) / 4 % 4) * 16 + (s - 2) % 4));
      chk("rot_qv", qv, 1'b1);
    end
    req = '0;
    step(); step();

    // Lone requester: re-granted at the cap with no gap.
    bc = 0;
    for (int c = 0; c < 7; c++) begin
      req = 4'b0100;
      data[2*W +: W] = 8'(8'h20 + bc);
      step();
      if (m_qv) bc++;
      chk("lone_gnt", gnt, 4'b0100);
    end
    req = '0;
    step();
    chk("lone_drop_gnt", gnt, 4'b0000);
    chk("lone_drop_busy", busy, 1'b0);
    chk("lone_q", q, 8'h25);

    // Owner drops mid-burst; waiting requester takes over at once.
    req = 4'b0010; data = 32'h4433_2211;
    step();
    chk("drop_g0", gnt, 4'b0010);
    req = 4'b1010;
    step();
    chk("drop_g1", gnt, 4'b0010);
    step();
    chk("drop_g2", gnt, 4'b0010);
    req = 4'b1000;
    step();
    chk("drop_g3", gnt, 4'b1000);
    chk("drop_qv", qv, 1'b0);

    // Two requesters alternate full bursts.
    reset = 1'b0; step();
    reset = 1'b1; req = 4'b0101;
    step();
    chk("alt_first", gnt, 4'b0001);
    for (int i = 0; i < 11; i++) begin
      data = $urandom;
      step();
      chk("alt_gnt", gnt, (((i + 1) / 4) % 2 == 1) ? 32'h4 : 32'h1);
    end

    // Reset lands on a beat in flight.
    req = '0; step();
    req = 4'b1000; data = 32'hA1B2_C3D4;
    step();
    chk("r6_gnt", gnt, 4'b1000);
    step();
    reset = 1'b0;
    step();
    chk("r6_gnt0", gnt, 4'b0000);
    chk("r6_q0", q, 8'h00);
    chk("r6_qv0", qv, 1'b0);
    reset = 1'b1;
    step();
    chk("r6_wrap", gnt, 4'b1000);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      req   = N'($urandom_range(0, 15));
      data  = $urandom;
      reset = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
